pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline control block for the 5-stage core. It replaces the stall-only hazard unit with parametrised forwarding, load-use detection and branch flush sequencing. It also adds a memory wait-state FSM that freezes the whole pipeline while the data SRAM is busy, plus saturating performance counters. It sits beside the datapath and drives every stage register's freeze/flush input and the EXE-stage operand muxes.

Parameters:
REG_AW, 4, register-address width (number of architectural registers = 2**REG_AW)
FWD_EN, 1, 1 = forwarding enabled (only load-use stalls); 0 = stall on any EXE/MEM RAW match
CNT_W, 32, width of each performance counter
MEM_TIMEOUT, 255, consecutive memory wait cycles before mem_timeout is raised (1..2**16-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
src1  in  REG_AW  ID-stage first source register
src2  in  REG_AW  ID-stage second source register
two_src  in  1  ID instruction reads src2
exe_src1  in  REG_AW  EXE-stage first source (forwarding compare)
exe_src2  in  REG_AW  EXE-stage second source
exe_dest  in  REG_AW  EXE-stage destination
exe_wb_en  in  1  EXE-stage writes back
exe_mem_r_en  in  1  EXE-stage is a load
mem_dest  in  REG_AW  MEM-stage destination
mem_wb_en  in  1  MEM-stage writes back
wb_dest  in  REG_AW  WB-stage destination
wb_wb_en  in  1  WB-stage writes back
branch_taken  in  1  EXE-stage branch resolved taken
mem_req  in  1  MEM stage performing a load/store
mem_ready  in  1  data SRAM completes the access this cycle
cnt_clr  in  1  synchronous clear of counters and mem_timeout
freeze_front  out  1  hold PC and IF/ID register
bubble_id  out  1  load ID/EXE register with a NOP (all enables 0)
freeze_all  out  1  hold every stage register, including PC
flush  out  1  clear IF/ID and ID/EXE registers
fwd_sel1  out  2  EXE operand-1 mux: 0 reg file, 1 from MEM, 2 from WB
fwd_sel2  out  2  EXE operand-2 mux, same encoding
mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
cyc_cnt  out  CNT_W  cycles since reset/clear
stall_cnt  out  CNT_W  cycles with bubble_id=1
memwait_cnt  out  CNT_W  cycles with freeze_all=1
flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- Reset (async): FSM=IDLE, wait counter=0, all counters=0, mem_timeout=0. Combinational outputs follow their equations during reset.
- mem_stall = mem_req & ~mem_ready. This signal is combinational and asserted in the first request cycle.
- freeze_all = mem_stall. While freeze_all=1: flush=0, bubble_id=0, freeze_front=0 (a global freeze supersedes all of them). branch_taken is held by the frozen EXE register and acts on the first unfrozen cycle.
- RAW hit (ID): (src1==exe_dest & exe_wb_en) or (two_src & src2==exe_dest & exe_wb_en), with the same terms for mem_dest/mem_wb_en.
- hazard: if FWD_EN=1, EXE terms only, and only when exe_mem_r_en=1 (load-use). If FWD_EN=0, any RAW hit.
- bubble_id = freeze_front = hazard & ~flush & ~freeze_all.
- flush = branch_taken & ~freeze_all. A branch in the same cycle as a hazard gives flush only.
- Forwarding (FWD_EN=1): fwd_sel1 = 1 if mem_wb_en & mem_dest==exe_src1; else 2 if wb_wb_en & wb_dest==exe_src1; else 0. MEM has priority over WB. fwd_sel2 follows the same rule using exe_src2. With FWD_EN=0 both are constant 0.
- FSM, states IDLE and WAIT:
  - IDLE -> WAIT when mem_stall.
  - WAIT -> IDLE when mem_ready.
  - The wait counter increments each WAIT cycle and is zeroed on entry to IDLE.
  - When the wait counter reaches MEM_TIMEOUT, mem_timeout is set (sticky). The FSM keeps waiting.
  - A single-cycle access (mem_req & mem_ready) stays in IDLE.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones, with no wrap.
  - cnt_clr zeroes all four counters and mem_timeout on the next edge. Clearing has priority over incrementing that cycle.
- Reset mid-WAIT returns to IDLE immediately; freeze_all then depends only on the current inputs.

Test Plan:
- Load-use: FWD_EN=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, src1=3 -> bubble_id=freeze_front=1 for 1 cycle; stall_cnt=1.
- ALU RAW with forwarding: mem_wb_en=1, mem_dest=5, wb_wb_en=1, wb_dest=5, exe_src1=5 -> fwd_sel1=1 (MEM priority), no bubble. Then drop mem_wb_en -> fwd_sel1=2.
- FWD_EN=0 instance: mem_wb_en=1, mem_dest=7, two_src=1, src2=7 -> bubble_id=1; fwd_sel1/2 stay 0.
- Branch during hazard: load-use condition plus branch_taken=1 -> flush=1, bubble_id=0; flush_cnt increments by 1.
- SRAM wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> freeze_all high for exactly 4 cycles; memwait_cnt=4; concurrent branch_taken gives flush only in the 5th cycle.
- Timeout/saturation: MEM_TIMEOUT=3, mem_ready=0 for 5 cycles -> mem_timeout=1 and stays high after mem_ready. cnt_clr clears it. CNT_W=2 with 6 hazard cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: hazard detection, EXE forwarding, branch flush,
// data-SRAM wait-state sequencing and saturating performance counters.
module pipe_ctrl #(
    parameter int REG_AW      = 4,
    parameter int FWD_EN      = 1,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic [REG_AW-1:0] exe_src1,
    input  logic [REG_AW-1:0] exe_src2,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_wb_en,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              cnt_clr,
    output logic              freeze_front,
    output logic              bubble_id,
    output logic              freeze_all,
    output logic              flush,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  memwait_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_WAIT = 1'b1;
    localparam logic [15:0] TMO_M1 = 16'(MEM_TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [15:0] r_wait;
    logic        r_timeout;
    logic        w_mem_stall;
    logic        w_exe_hit;
    logic        w_mem_hit;
    logic        w_hazard;

    assign w_mem_stall = mem_req & ~mem_ready;

    assign w_exe_hit = exe_wb_en &
        ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
    assign w_mem_hit = mem_wb_en &
        ((src1 == mem_dest) | (two_src & (src2 == mem_dest)));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign w_hazard = (FWD_EN != 0) ? (w_exe_hit & exe_mem_r_en)
                                    : (w_exe_hit | w_mem_hit);

    assign freeze_all   = w_mem_stall;
    assign flush        = branch_taken & ~w_mem_stall;
    assign bubble_id    = w_hazard & ~flush & ~w_mem_stall;
    assign freeze_front = bubble_id;
    assign mem_timeout  = r_timeout;

    always_comb begin
        fwd_sel1 = 2'd0;
        fwd_sel2 = 2'd0;
        if (FWD_EN != 0) begin
            if (mem_wb_en && mem_dest == exe_src1)
                fwd_sel1 = 2'd1;
            else if (wb_wb_en && wb_dest == exe_src1)
                fwd_sel1 = 2'd2;
            if (mem_wb_en && mem_dest == exe_src2)
                fwd_sel2 = 2'd1;
            else if (wb_wb_en && wb_dest == exe_src2)
                fwd_sel2 = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (w_mem_stall)
                        r_state <= S_WAIT;
                end
                default: begin
                    if (mem_ready) begin
                        r_state <= S_IDLE;
                        r_wait  <= '0;
                    end else if (r_wait != '1) begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
            endcase
            if (cnt_clr)
                r_timeout <= 1'b0;
            else if (r_state == S_WAIT && !mem_ready && r_wait == TMO_M1)
                r_timeout <= 1'b1;
        end
    end

    function automatic logic [CNT_W-1:0] f_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt     <= '0;
            stall_cnt   <= '0;
            memwait_cnt <= '0;
            flush_cnt   <= '0;
        end else if (cnt_clr) begin
            cyc_cnt     <= '0;
            stall_cnt   <= '0;
            memwait_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            cyc_cnt     <= f_inc(cyc_cnt, 1'b1);
            stall_cnt   <= f_inc(stall_cnt, bubble_id);
            memwait_cnt <= f_inc(memwait_cnt, freeze_all);
            flush_cnt   <= f_inc(flush_cnt, flush);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: forwarding instance, stall-only
// instance, and a short-timeout / narrow-counter instance on shared inputs.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src1, src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
    logic       branch_taken, mem_req, mem_ready, cnt_clr;

    logic        a_ff, a_bub, a_fa, a_fl, a_tmo;
    logic [1:0]  a_fs1, a_fs2;
    logic [31:0] a_cyc, a_stc, a_mwc, a_flc;
    logic        b_ff, b_bub, b_fa, b_fl, b_tmo;
    logic [1:0]  b_fs1, b_fs2;
    logic [31:0] b_cyc, b_stc, b_mwc, b_flc;
    logic        c_ff, c_bub, c_fa, c_fl, c_tmo;
    logic [1:0]  c_fs1, c_fs2;
    logic [1:0]  c_cyc, c_stc, c_mwc, c_flc;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_AW(4), .FWD_EN(1), .CNT_W(32), .MEM_TIMEOUT(255)) u_a (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
        .wb_wb_en(wb_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr), .freeze_front(a_ff),
        .bubble_id(a_bub), .freeze_all(a_fa), .flush(a_fl),
        .fwd_sel1(a_fs1), .fwd_sel2(a_fs2), .mem_timeout(a_tmo),
        .cyc_cnt(a_cyc), .stall_cnt(a_stc), .memwait_cnt(a_mwc),
        .flush_cnt(a_flc)
    );

    pipe_ctrl #(.REG_AW(4), .FWD_EN(0), .CNT_W(32), .MEM_TIMEOUT(255)) u_b (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
        .wb_wb_en(wb_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr), .freeze_front(b_ff),
        .bubble_id(b_bub), .freeze_all(b_fa), .flush(b_fl),
        .fwd_sel1(b_fs1), .fwd_sel2(b_fs2), .mem_timeout(b_tmo),
        .cyc_cnt(b_cyc), .stall_cnt(b_stc), .memwait_cnt(b_mwc),
        .flush_cnt(b_flc)
    );

    pipe_ctrl #(.REG_AW(4), .FWD_EN(1), .CNT_W(2), .MEM_TIMEOUT(3)) u_c (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
        .wb_wb_en(wb_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr), .freeze_front(c_ff),
        .bubble_id(c_bub), .freeze_all(c_fa), .flush(c_fl),
        .fwd_sel1(c_fs1), .fwd_sel2(c_fs2), .mem_timeout(c_tmo),
        .cyc_cnt(c_cyc), .stall_cnt(c_stc), .memwait_cnt(c_mwc),
        .flush_cnt(c_flc)
    );

    localparam int BUB = 0, FRZF = 1, FALL = 2, FLS = 3, FS1 = 4, FS2 = 5;
    localparam int TMO = 6, CYC = 7, STC = 8, MWC = 9, FLC = 10;
    localparam int B_BUB = 11, B_FS1 = 12, B_FS2 = 13;
    localparam int C_TMO = 14, C_STC = 15;

    typedef struct {
        string       tag;
        int          id;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs(input int id);
        case (id)
            BUB:     return 32'(a_bub);
            FRZF:    return 32'(a_ff);
            FALL:    return 32'(a_fa);
            FLS:     return 32'(a_fl);
            FS1:     return 32'(a_fs1);
            FS2:     return 32'(a_fs2);
            TMO:     return 32'(a_tmo);
            CYC:     return a_cyc;
            STC:     return a_stc;
            MWC:     return a_mwc;
            FLC:     return a_flc;
            B_BUB:   return 32'(b_bub);
            B_FS1:   return 32'(b_fs1);
            B_FS2:   return 32'(b_fs2);
            C_TMO:   return 32'(c_tmo);
            C_STC:   return 32'(c_stc);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic exp_v(input int id, input logic [31:0] v,
                         input string tag);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs(e.id), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        src1 = 0; src2 = 0; two_src = 0;
        exe_src1 = 0; exe_src2 = 0; exe_dest = 0;
        exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; wb_dest = 0; wb_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    task automatic clr();
        clear_in();
        cnt_clr = 1;
        step();
        cnt_clr = 0;
    endtask

    task automatic load_use();
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; src1 = 3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not end");
        $fatal(1);
    end

    initial begin
        rst = 1;
        clear_in();
        mem_req = 1;
        exp_v(FALL, 1, "rst_freeze_follows");
        exp_v(CYC, 0, "rst_cyc");
        exp_v(STC, 0, "rst_stc");
        exp_v(MWC, 0, "rst_mwc");
        exp_v(TMO, 0, "rst_tmo");
        exp_v(C_TMO, 0, "rst_c_tmo");
        step();
        rst = 0;
        clear_in();
        clr();

        load_use();
        exp_v(BUB, 1, "lu_bub");
        exp_v(FRZF, 1, "lu_frzf");
        exp_v(FLS, 0, "lu_fls");
        exp_v(FALL, 0, "lu_fall");
        exp_v(B_BUB, 1, "lu_b_bub");
        exp_v(STC, 0, "lu_stc_pre");
        step();
        clear_in();
        exp_v(BUB, 0, "lu_after_bub");
        exp_v(FRZF, 0, "lu_after_frzf");
        exp_v(STC, 1, "lu_stc");
        exp_v(CYC, 1, "lu_cyc");
        step();

        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3;
        src1 = 1; src2 = 3; two_src = 0;
        exp_v(BUB, 0, "src2_unused");
        step();
        two_src = 1;
        exp_v(BUB, 1, "src2_used");
        step();
        clear_in();
        exe_wb_en = 1; exe_dest = 3; src1 = 3;
        exp_v(BUB, 0, "alu_raw_fwd");
        exp_v(B_BUB, 1, "alu_raw_nofwd");
        step();

        clear_in();
        mem_wb_en = 1; mem_dest = 5; wb_wb_en = 1; wb_dest = 5;
        exe_src1 = 5;
        exp_v(FS1, 1, "fwd_mem_prio");
        exp_v(FS2, 0, "fwd2_none");
        exp_v(BUB, 0, "fwd_no_bub");
        exp_v(B_FS1, 0, "nofwd_fs1");
        step();
        mem_wb_en = 0; exe_src2 = 5;
        exp_v(FS1, 2, "fwd_wb");
        exp_v(FS2, 2, "fwd2_wb");
        exp_v(B_FS2, 0, "nofwd_fs2");
        step();
        mem_wb_en = 1; mem_dest = 6; exe_src2 = 6;
        exp_v(FS1, 2, "fwd_mix1");
        exp_v(FS2, 1, "fwd_mix2");
        step();

        clear_in();
        mem_wb_en = 1; mem_dest = 7; two_src = 1; src2 = 7; exe_src1 = 7;
        exp_v(B_BUB, 1, "nofwd_mem_raw");
        exp_v(B_FS1, 0, "nofwd_fs1_zero");
        exp_v(BUB, 0, "fwd_mem_no_bub");
        exp_v(FS1, 1, "fwd_mem_sel");
        step();
        clear_in();
        wb_wb_en = 1; wb_dest = 2; src1 = 2;
        exp_v(B_BUB, 0, "nofwd_wb_ignored");
        step();

        clr();
        load_use();
        branch_taken = 1;
        exp_v(FLS, 1, "br_haz_fls");
        exp_v(BUB, 0, "br_haz_bub");
        exp_v(FRZF, 0, "br_haz_frzf");
        exp_v(B_BUB, 0, "br_haz_b_bub");
        step();
        clear_in();
        exp_v(FLC, 1, "br_flc");
        exp_v(STC, 0, "br_stc");
        step();

        clr();
        for (int i = 0; i < 4; i++) begin
            load_use();
            branch_taken = 1; mem_req = 1; mem_ready = 0;
            exp_v(FALL, 1, "wait_fall");
            exp_v(FLS, 0, "wait_fls");
            exp_v(BUB, 0, "wait_bub");
            exp_v(FRZF, 0, "wait_frzf");
            exp_v(MWC, 32'(i), "wait_mwc");
            exp_v(CYC, 32'(i), "wait_cyc");
            step();
        end
        mem_ready = 1;
        exp_v(FALL, 0, "ready_fall");
        exp_v(FLS, 1, "ready_fls");
        exp_v(BUB, 0, "ready_bub");
        exp_v(MWC, 4, "ready_mwc");
        exp_v(FLC, 0, "ready_flc_pre");
        step();
        clear_in();
        exp_v(FLC, 1, "wait_flc");
        exp_v(MWC, 4, "wait_mwc_final");
        exp_v(STC, 0, "wait_stc");
        exp_v(TMO, 0, "wait_no_tmo");
        step();

        clr();
        for (int i = 0; i < 5; i++) begin
            mem_req = 1; mem_ready = 0;
            step();
        end
        mem_ready = 1;
        exp_v(C_TMO, 1, "tmo_set");
        exp_v(TMO, 0, "tmo_long_limit");
        step();
        clear_in();
        exp_v(C_TMO, 1, "tmo_sticky");
        step();
        cnt_clr = 1;
        exp_v(C_TMO, 1, "tmo_before_clr");
        step();
        cnt_clr = 0;
        exp_v(C_TMO, 0, "tmo_cleared");
        step();
        for (int i = 0; i < 2; i++) begin
            mem_req = 1; mem_ready = 0;
            step();
        end
        mem_ready = 1;
        step();
        clear_in();
        exp_v(C_TMO, 0, "tmo_short_wait");
        step();

        clr();
        for (int i = 0; i < 6; i++) begin
            load_use();
            step();
        end
        clear_in();
        exp_v(C_STC, 3, "sat_c_stc");
        exp_v(STC, 6, "sat_a_stc");
        step();
        load_use();
        cnt_clr = 1;
        step();
        clear_in();
        exp_v(STC, 0, "clr_over_inc");
        exp_v(C_STC, 0, "clr_over_inc_c");
        step();

        mem_req = 1; mem_ready = 0;
        step();
        step();
        rst = 1; mem_req = 0;
        #1;
        exp_v(FALL, 0, "rst_mid_wait_fall");
        exp_v(MWC, 0, "rst_mid_wait_mwc");
        step();
        rst = 0;
        clear_in();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
